// File: rtl/pipeline_pkg.sv
// Shared types and constants for the in-order pipeline hazard controller.
package pipeline_pkg;

  // Decode instruction class as presented on instr_class.
  typedef enum logic [3:0] {
    ClsNone  = 4'h0,
    ClsBr1   = 4'h1,
    ClsBr2   = 4'h2,
    ClsBr3   = 4'h3,
    ClsBr4   = 4'h4,
    ClsBr5   = 4'h5,
    ClsCall  = 4'h6,
    ClsRet   = 4'h7,
    ClsReti  = 4'h8,
    ClsRetid = 4'h9,
    ClsRetie = 4'hA
  } instr_class_e;

  typedef enum logic [1:0] {
    StReset,
    StCheck,
    StStall,
    StFlush
  } hz_state_e;

  // Forward mux selects per operand.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_WB = 2'd2;

  // All return-class instructions share the same flush depth.
  function automatic logic is_ret_class(input logic [3:0] cls);
    return (cls == ClsRet) || (cls == ClsReti) || (cls == ClsRetid) || (cls == ClsRetie);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Per-operand forwarding compare: selects EX/WB/regfile source and flags load-use.
module hazard_fwd_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic              src_valid,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_wen,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              wb_wen,
  output logic [1:0]        fwd_sel,
  output logic              load_use
);

  logic w_ex_hit;
  logic w_wb_hit;

  assign w_ex_hit = src_valid && ex_wen && (src_addr == ex_dst);
  assign w_wb_hit = src_valid && wb_wen && (src_addr == wb_dst);
  // A load result is not available in EX, so an EX hit on a load must stall.
  assign load_use = w_ex_hit && ex_is_load;

  // EX holds the younger value, so it takes precedence over WB.
  always_comb begin
    fwd_sel = FWD_RF;
    if (w_ex_hit) begin
      fwd_sel = FWD_EX;
    end else if (w_wb_hit) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/flush controller: forwarding selects, load-use stall, interrupt entry and
// counter-driven NOP injection after control-flow changes.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned BR_DEPTH  = 2,
  parameter int unsigned RET_DEPTH = 2,
  parameter int unsigned INT_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [REG_AW-1:0]         ex_dst,
  input  logic                      ex_wen,
  input  logic                      ex_is_load,
  input  logic [REG_AW-1:0]         wb_dst,
  input  logic                      wb_wen,
  input  logic [3:0]                instr_class,
  input  logic                      branch_taken,
  input  logic                      int_req,
  input  logic                      int_en,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      fetch_en,
  output logic                      pc_hold,
  output logic                      pc_load,
  output logic                      pc_int,
  output logic                      int_ack,
  output logic                      dec_nop,
  output logic                      busy
);

  localparam logic [2:0] BrCnt  = 3'(BR_DEPTH);
  localparam logic [2:0] RetCnt = 3'(RET_DEPTH);
  localparam logic [2:0] IntCnt = 3'(INT_DEPTH);

  hz_state_e          r_state;
  hz_state_e          w_state_d;
  logic [2:0]         r_cnt;
  logic [2:0]         w_cnt_d;
  logic [NUM_SRC-1:0] w_lu_vec;
  logic               w_load_use;

  for (genvar g = 0; g < NUM_SRC; g++) begin : gen_fwd
    hazard_fwd_unit #(
      .REG_AW (REG_AW)
    ) u_fwd (
      .src_addr   (src_addr[g*REG_AW +: REG_AW]),
      .src_valid  (src_valid[g]),
      .ex_dst     (ex_dst),
      .ex_wen     (ex_wen),
      .ex_is_load (ex_is_load),
      .wb_dst     (wb_dst),
      .wb_wen     (wb_wen),
      .fwd_sel    (fwd_sel[2*g +: 2]),
      .load_use   (w_lu_vec[g])
    );
  end

  assign w_load_use = |w_lu_vec;

  // State and flush counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StReset;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Next-state, counter reload and priority-resolved pipeline controls.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    fetch_en  = 1'b0;
    pc_hold   = 1'b0;
    pc_load   = 1'b0;
    pc_int    = 1'b0;
    int_ack   = 1'b0;
    dec_nop   = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      StReset: begin
        pc_hold   = 1'b1;
        dec_nop   = 1'b1;
        w_cnt_d   = '0;
        w_state_d = StCheck;
      end
      StCheck: begin
        busy     = 1'b0;
        fetch_en = 1'b1;
        if (branch_taken) begin
          pc_load   = 1'b1;
          dec_nop   = 1'b1;
          w_cnt_d   = BrCnt;
          w_state_d = StFlush;
        end else if (int_req && int_en) begin
          int_ack   = 1'b1;
          pc_int    = 1'b1;
          dec_nop   = 1'b1;
          w_cnt_d   = IntCnt;
          w_state_d = StFlush;
        end else if (instr_class == ClsCall) begin
          dec_nop   = 1'b1;
          w_cnt_d   = BrCnt;
          w_state_d = StFlush;
        end else if (is_ret_class(instr_class)) begin
          dec_nop   = 1'b1;
          w_cnt_d   = RetCnt;
          w_state_d = StFlush;
        end else if (w_load_use) begin
          fetch_en  = 1'b0;
          pc_hold   = 1'b1;
          dec_nop   = 1'b1;
          w_state_d = StStall;
        end
      end
      StStall: begin
        // Single bubble: the load reaches WB next cycle and is forwarded from there.
        pc_hold   = 1'b1;
        dec_nop   = 1'b1;
        w_state_d = StCheck;
      end
      StFlush: begin
        fetch_en = 1'b1;
        dec_nop  = 1'b1;
        if (branch_taken) begin
          pc_load = 1'b1;
          w_cnt_d = BrCnt;
        end else if (r_cnt == 3'd1) begin
          w_cnt_d   = '0;
          w_state_d = StCheck;
        end else begin
          w_cnt_d = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_d = StReset;
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_AW    = 5;
  localparam int unsigned NUM_SRC   = 2;
  localparam int unsigned BR_DEPTH  = 2;
  localparam int unsigned RET_DEPTH = 3;
  localparam int unsigned INT_DEPTH = 2;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_SRC*REG_AW-1:0] src_addr;
  logic [NUM_SRC-1:0]        src_valid;
  logic [REG_AW-1:0]         ex_dst;
  logic                      ex_wen;
  logic                      ex_is_load;
  logic [REG_AW-1:0]         wb_dst;
  logic                      wb_wen;
  logic [3:0]                instr_class;
  logic                      branch_taken;
  logic                      int_req;
  logic                      int_en;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      fetch_en;
  logic                      pc_hold;
  logic                      pc_load;
  logic                      pc_int;
  logic                      int_ack;
  logic                      dec_nop;
  logic                      busy;

  pipeline_hazard_ctrl #(
    .REG_AW    (REG_AW),
    .NUM_SRC   (NUM_SRC),
    .BR_DEPTH  (BR_DEPTH),
    .RET_DEPTH (RET_DEPTH),
    .INT_DEPTH (INT_DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .src_addr     (src_addr),
    .src_valid    (src_valid),
    .ex_dst       (ex_dst),
    .ex_wen       (ex_wen),
    .ex_is_load   (ex_is_load),
    .wb_dst       (wb_dst),
    .wb_wen       (wb_wen),
    .instr_class  (instr_class),
    .branch_taken (branch_taken),
    .int_req      (int_req),
    .int_en       (int_en),
    .fwd_sel      (fwd_sel),
    .fetch_en     (fetch_en),
    .pc_hold      (pc_hold),
    .pc_load      (pc_load),
    .pc_int       (pc_int),
    .int_ack      (int_ack),
    .dec_nop      (dec_nop),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Packed response: {fwd_sel[3:0], fetch_en, pc_hold, pc_load, pc_int, int_ack, dec_nop, busy}
  typedef struct {
    logic [10:0] val;
    logic [10:0] mask;
    string       name;
  } exp_t;

  localparam logic [10:0] M_ALL  = 11'h7FF;
  localparam logic [10:0] M_NOFE = 11'h7BF;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [10:0] mk(input logic [3:0] fwd, input logic fe, input logic ph,
                                     input logic pl, input logic pi, input logic ia,
                                     input logic dn, input logic bz);
    return {fwd, fe, ph, pl, pi, ia, dn, bz};
  endfunction

  logic [10:0] e_rst;
  logic [10:0] e_idle;
  logic [10:0] e_flush;

  // Push the expected response for the current cycle, then advance to just after the edge.
  task automatic cyc(input string name, input logic [10:0] val, input logic [10:0] mask);
    exp_t e;
    e.val  = val;
    e.mask = mask;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    src_addr     = '0;
    src_valid    = '0;
    ex_dst       = '0;
    ex_wen       = 1'b0;
    ex_is_load   = 1'b0;
    wb_dst       = '0;
    wb_wen       = 1'b0;
    instr_class  = 4'h0;
    branch_taken = 1'b0;
    int_req      = 1'b0;
    int_en       = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [4:0] r, input logic v);
    src_addr[i*REG_AW +: REG_AW] = r;
    src_valid[i]                 = v;
  endtask

  // Monitor: outputs are sampled at the falling edge, away from state updates.
  exp_t        mon_e;
  logic [10:0] mon_act;
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = {fwd_sel, fetch_en, pc_hold, pc_load, pc_int, int_ack, dec_nop, busy};
      n_vec   = n_vec + 1;
      if ((mon_act & mon_e.mask) != (mon_e.val & mon_e.mask)) begin
        n_miss = n_miss + 1;
        $display("FAIL %s: got %03h want %03h (mask %03h) at %0t", mon_e.name, mon_act,
                 mon_e.val, mon_e.mask, $time);
      end
    end
  end

  initial begin
    e_rst   = mk(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    e_idle  = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e_flush = mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset held 3 cycles; control requests during reset must be ignored.
    branch_taken = 1'b1;
    int_req      = 1'b1;
    int_en       = 1'b1;
    cyc("reset0", e_rst, M_ALL);
    idle_inputs();
    cyc("reset1", e_rst, M_ALL);
    cyc("reset2", e_rst, M_ALL);
    reset_n = 1'b1;
    cyc("rst_hold", e_rst, M_ALL);
    cyc("first_check", e_idle, M_ALL);

    // Forwarding selects.
    set_src(0, 5'd3, 1'b1);
    ex_dst = 5'd3; ex_wen = 1'b1; wb_dst = 5'd3; wb_wen = 1'b1;
    cyc("fwd_ex_wins", mk(4'b0001, 1, 0, 0, 0, 0, 0, 0), M_ALL);
    ex_wen = 1'b0;
    cyc("fwd_wb", mk(4'b0010, 1, 0, 0, 0, 0, 0, 0), M_ALL);
    src_valid[0] = 1'b0;
    cyc("fwd_invalid", e_idle, M_ALL);
    set_src(0, 5'd3, 1'b1);
    set_src(1, 5'd9, 1'b1);
    ex_wen = 1'b1; wb_dst = 5'd9;
    cyc("fwd_both_ops", mk(4'b1001, 1, 0, 0, 0, 0, 0, 0), M_ALL);
    idle_inputs();

    // Load-use: one stall cycle, then the load is forwarded from WB.
    set_src(1, 5'd7, 1'b1);
    ex_dst = 5'd7; ex_wen = 1'b1; ex_is_load = 1'b1;
    cyc("lu_detect", mk(4'b0100, 0, 1, 0, 0, 0, 1, 0), M_ALL);
    ex_wen = 1'b0; ex_is_load = 1'b0; wb_dst = 5'd7; wb_wen = 1'b1;
    cyc("lu_stall", mk(4'b1000, 0, 1, 0, 0, 0, 1, 1), M_ALL);
    cyc("lu_resume", mk(4'b1000, 1, 0, 0, 0, 0, 0, 0), M_ALL);
    idle_inputs();
    cyc("lu_clear", e_idle, M_ALL);

    // Taken branch: pc_load once, NOP for 1 + BR_DEPTH cycles.
    branch_taken = 1'b1;
    cyc("br_take", mk(4'b0000, 0, 0, 1, 0, 0, 1, 0), M_NOFE);
    branch_taken = 1'b0;
    for (int k = 0; k < BR_DEPTH; k++) cyc("br_flush", e_flush, M_ALL);
    cyc("br_done", e_idle, M_ALL);

    // Branch beats interrupt; interrupt stays pending through flush and a re-branch.
    branch_taken = 1'b1; int_req = 1'b1; int_en = 1'b1;
    cyc("br_over_int", mk(4'b0000, 0, 0, 1, 0, 0, 1, 0), M_NOFE);
    branch_taken = 1'b0;
    cyc("int_pend_f2", e_flush, M_ALL);
    branch_taken = 1'b1;
    cyc("flush_rebranch", mk(4'b0000, 1, 0, 1, 0, 0, 1, 1), M_ALL);
    branch_taken = 1'b0;
    cyc("int_pend_f2b", e_flush, M_ALL);
    cyc("int_pend_f1", e_flush, M_ALL);
    cyc("int_accept", mk(4'b0000, 0, 0, 0, 1, 1, 1, 0), M_NOFE);
    int_req = 1'b0;
    for (int k = 0; k < INT_DEPTH; k++) cyc("int_flush", e_flush, M_ALL);
    cyc("int_done", e_idle, M_ALL);

    // Masked interrupt is never accepted.
    int_req = 1'b1; int_en = 1'b0;
    for (int k = 0; k < 3; k++) cyc("int_masked", e_idle, M_ALL);
    idle_inputs();

    // CALL flushes BR_DEPTH; it outranks a simultaneous load-use.
    instr_class = 4'h6;
    set_src(0, 5'd4, 1'b1);
    ex_dst = 5'd4; ex_wen = 1'b1; ex_is_load = 1'b1;
    cyc("call_over_lu", mk(4'b0001, 0, 0, 0, 0, 0, 1, 0), M_NOFE);
    idle_inputs();
    for (int k = 0; k < BR_DEPTH; k++) cyc("call_flush", e_flush, M_ALL);
    cyc("call_done", e_idle, M_ALL);

    // RETI flushes RET_DEPTH.
    instr_class = 4'h8;
    cyc("reti", mk(4'b0000, 0, 0, 0, 0, 0, 1, 0), M_NOFE);
    instr_class = 4'h0;
    for (int k = 0; k < RET_DEPTH; k++) cyc("ret_flush", e_flush, M_ALL);
    cyc("ret_done", e_idle, M_ALL);

    // Untaken conditional branch class: predicted not-taken, no flush.
    instr_class = 4'h3;
    cyc("br_class_nt", e_idle, M_ALL);
    instr_class = 4'h0;
    cyc("br_class_nt2", e_idle, M_ALL);

    // Reset asserted mid-flush (cnt==1) takes effect immediately.
    branch_taken = 1'b1;
    cyc("pre_rst_br", mk(4'b0000, 0, 0, 1, 0, 0, 1, 0), M_NOFE);
    branch_taken = 1'b0;
    cyc("pre_rst_f2", e_flush, M_ALL);
    int_req = 1'b1; int_en = 1'b1; branch_taken = 1'b1;
    reset_n = 1'b0;
    cyc("rst_mid_flush", e_rst, M_ALL);
    cyc("rst_mid_held", e_rst, M_ALL);
    idle_inputs();
    reset_n = 1'b1;
    cyc("rst2_hold", e_rst, M_ALL);
    cyc("rst2_check", e_idle, M_ALL);
    cyc("rst2_check2", e_idle, M_ALL);

    // Drain scoreboard with a bound.
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_miss = n_miss + 1;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
